// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-phase bundled-data bridges feeding the cache controller.
package cache_ctrl_pkg;

  localparam int unsigned DATA_W_DEFAULT      = 32;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef logic phase_t;

  function automatic phase_t phase_flip(input phase_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/async_req_bridge_if.sv
// Upstream 2-phase request/ack bundle plus downstream valid/ready stream.
interface async_req_bridge_if
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  phase_t              inR;
  logic [DATA_W-1:0]   inData;
  phase_t              outA;
  logic                valid_o;
  logic [DATA_W-1:0]   data_o;
  logic                ready_i;

  modport master (
    output inR, inData, ready_i,
    input  outA, valid_o, data_o
  );

  modport slave (
    input  inR, inData, ready_i,
    output outA, valid_o, data_o
  );

endinterface

// File: rtl/sync_nff.sv
// N-flop synchronizer with asynchronous active-low clear to 0.
module sync_nff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_req_bridge.sv
// Terminates a 2-phase bundled-data pipeline: synchronizes inR, captures tokens
// into a small FIFO, returns outA per capture, and presents a valid/ready stream.
module async_req_bridge
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEPTH       = 2
) (
  input  logic              clk,
  input  logic              rstn,
  async_req_bridge_if.slave bus
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  phase_t            r_phase;
  phase_t            r_outA;

  phase_t w_sync;
  logic   w_pending;
  logic   w_push;
  logic   w_pop;

  sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (bus.inR),
    .o_q  (w_sync)
  );

  // Full is judged on the registered count, so a pop never frees a slot for a
  // push on the same edge; a stalled token lands one edge after the pop.
  assign w_pending = (w_sync != r_phase);
  assign w_push    = w_pending && (r_count < FULL_CNT);
  assign w_pop     = (r_count != '0) && bus.ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem   <= '{default: '0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_phase <= 1'b0;
      r_outA  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= bus.inData;
        r_tail        <= r_tail + PTR_W'(1);
        r_phase       <= w_sync;
        r_outA        <= phase_flip(r_outA);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.outA    = r_outA;
  assign bus.valid_o = (r_count != '0);
  assign bus.data_o  = r_mem[r_head];

endmodule

// File: tb/tb_async_req_bridge.sv
// Directed, table-driven bench for async_req_bridge with default parameters.
module tb_async_req_bridge;

  logic clk;
  logic rstn;

  async_req_bridge_if #(.DATA_W(32)) bus ();

  async_req_bridge #(
    .DATA_W      (32),
    .SYNC_STAGES (2),
    .DEPTH       (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        inR;
    logic [31:0] data;
    logic        rdy;
    logic        exp_outA;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  int unsigned n_cmp;
  int unsigned n_err;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic e_outA, input logic e_valid,
                           input int unsigned e_cnt);
    chk({tag, ".outA"},  {31'd0, bus.outA},    {31'd0, e_outA});
    chk({tag, ".valid"}, {31'd0, bus.valid_o}, {31'd0, e_valid});
    chk({tag, ".count"}, 32'(dut.r_count),     e_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Single token then four back-to-back tokens; one row per clock edge.
    vecs.push_back('{1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001});
    vecs.push_back('{1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1});
    vecs.push_back('{1'b0, 32'h2, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h2, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2});
    vecs.push_back('{1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3});
    vecs.push_back('{1'b0, 32'h4, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h4, 1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4});
    vecs.push_back('{1'b0, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0});

    // Reset with inR=1 held: exactly one token after release.
    rstn        = 1'b0;
    bus.inR     = 1'b1;
    bus.inData  = 32'hDEAD_0000;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d.outA", i),  {31'd0, bus.outA},    32'd0);
      chk($sformatf("rst%0d.valid", i), {31'd0, bus.valid_o}, 32'd0);
    end
    rstn = 1'b1;
    tick(); chk_state("rel_e0", 1'b0, 1'b0, 0);
    tick(); chk_state("rel_e1", 1'b0, 1'b0, 0);
    tick(); chk_state("rel_e2", 1'b1, 1'b1, 1);
    chk("rel_e2.data", bus.data_o, 32'hDEAD_0000);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_state($sformatf("rel_idle%0d", i), 1'b1, 1'b0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      bus.inR     = vecs[i].inR;
      bus.inData  = vecs[i].data;
      bus.ready_i = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d.outA", i),  {31'd0, bus.outA},    {31'd0, vecs[i].exp_outA});
      chk($sformatf("vec%0d.valid", i), {31'd0, bus.valid_o}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d.data", i), bus.data_o, vecs[i].exp_data);
    end

    // Full stall: third token held off until a pop frees a slot.
    bus.ready_i = 1'b0;
    bus.inR = 1'b1; bus.inData = 32'h1;
    repeat (3) tick();
    chk_state("full_t1", 1'b1, 1'b1, 1);
    bus.inR = 1'b0; bus.inData = 32'h2;
    repeat (3) tick();
    chk_state("full_t2", 1'b0, 1'b1, 2);
    bus.inR = 1'b1; bus.inData = 32'h3;
    repeat (5) tick();
    chk_state("full_t3", 1'b0, 1'b1, 2);
    chk("full_t3.data", bus.data_o, 32'h1);
    bus.ready_i = 1'b1;
    tick();
    chk_state("full_pop", 1'b0, 1'b1, 1);
    chk("full_pop.data", bus.data_o, 32'h2);
    bus.ready_i = 1'b0;
    tick();
    chk_state("full_cap", 1'b1, 1'b1, 2);
    bus.ready_i = 1'b1;
    tick();
    chk("full_drain.data", bus.data_o, 32'h3);
    chk_state("full_drain", 1'b1, 1'b1, 1);
    tick();
    chk_state("full_empty", 1'b1, 1'b0, 0);
    bus.ready_i = 1'b0;

    // Push and pop on the same edge at count=1.
    bus.inR = 1'b0; bus.inData = 32'hB0;
    repeat (3) tick();
    chk_state("sim_a", 1'b0, 1'b1, 1);
    chk("sim_a.data", bus.data_o, 32'hB0);
    bus.inR = 1'b1; bus.inData = 32'hB1;
    tick(); tick();
    chk_state("sim_pre", 1'b0, 1'b1, 1);
    bus.ready_i = 1'b1;
    tick();
    chk_state("sim_pp", 1'b1, 1'b1, 1);
    chk("sim_pp.data", bus.data_o, 32'hB1);
    tick();
    bus.ready_i = 1'b0;
    chk_state("sim_drain", 1'b1, 1'b0, 0);

    // Asynchronous reset with FIFO full and a token pending.
    bus.inR = 1'b0; bus.inData = 32'hC0;
    repeat (3) tick();
    chk_state("mid_c0", 1'b0, 1'b1, 1);
    bus.inR = 1'b1; bus.inData = 32'hC1;
    repeat (3) tick();
    chk_state("mid_c1", 1'b1, 1'b1, 2);
    bus.inR = 1'b0; bus.inData = 32'hC2;
    repeat (3) tick();
    chk_state("mid_c2", 1'b1, 1'b1, 2);
    #3;
    rstn = 1'b0;
    #1;
    chk_state("mid_rst", 1'b0, 1'b0, 0);
    tick();
    chk_state("mid_rst_hold", 1'b0, 1'b0, 0);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk_state($sformatf("mid_post%0d", i), 1'b0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
